// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 access codes and the size field
// carried in funct3[1:0].
package riscv_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

endpackage

// File: rtl/load_extend.sv
// Load alignment and extension: picks the addressed byte/halfword out of a
// little-endian word and sign- or zero-extends it according to funct3.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  lane,
    input  logic [2:0]  ctrl,
    output logic [31:0] data
);

    logic [7:0]  sel_byte_s;
    logic [15:0] sel_half_s;

    // Lane selection and extension.
    always_comb begin
        sel_byte_s = 8'h00;
        sel_half_s = 16'h0000;
        data       = 32'h0000_0000;

        case (lane)
            2'b00:   sel_byte_s = raw_word[7:0];
            2'b01:   sel_byte_s = raw_word[15:8];
            2'b10:   sel_byte_s = raw_word[23:16];
            2'b11:   sel_byte_s = raw_word[31:24];
            default: sel_byte_s = 8'h00;
        endcase

        // lane[0] is deliberately ignored for halfwords: no misalignment trap.
        if (lane[1]) begin
            sel_half_s = raw_word[31:16];
        end else begin
            sel_half_s = raw_word[15:0];
        end

        case (ctrl)
            DM_B:    data = {{24{sel_byte_s[7]}}, sel_byte_s};
            DM_BU:   data = {24'h00_0000, sel_byte_s};
            DM_H:    data = {{16{sel_half_s[15]}}, sel_half_s};
            DM_HU:   data = {16'h0000, sel_half_s};
            DM_W:    data = raw_word;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory for the single-cycle core:
// combinational loads, synchronous B/H/W stores and synchronous clear.
module data_memory
    import riscv_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] address,
    input  logic [31:0] dataWr,
    input  logic        dmWr,
    input  logic [2:0]  dmCtrl,
    output logic [31:0] dataRd
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] word_idx_s;
    logic [3:0]    byte_en_s;
    logic [31:0]   wr_data_s;
    logic          unused_s;

    // Addresses wrap modulo 4*DEPTH, so the upper bits play no part.
    assign word_idx_s = address[AW+1:2];
    assign unused_s   = ^address[31:AW+2];

    // Store lane enables and lane-replicated store data.
    always_comb begin
        byte_en_s = 4'b0000;
        wr_data_s = 32'h0000_0000;
        case (dmCtrl[1:0])
            SZ_BYTE: begin
                byte_en_s = 4'b0001 << address[1:0];
                wr_data_s = {4{dataWr[7:0]}};
            end
            SZ_HALF: begin
                if (address[1]) begin
                    byte_en_s = 4'b1100;
                end else begin
                    byte_en_s = 4'b0011;
                end
                wr_data_s = {2{dataWr[15:0]}};
            end
            SZ_WORD: begin
                byte_en_s = 4'b1111;
                wr_data_s = dataWr;
            end
            default: begin
                byte_en_s = 4'b0000;
                wr_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Storage array: clear has priority over a simultaneous store.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (dmWr) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .raw_word (mem_r[word_idx_s]),
        .lane     (address[1:0]),
        .ctrl     (dmCtrl),
        .data     (dataRd)
    );

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table followed by
// randomized traffic checked against a byte-array reference model.
module tb_data_memory;

    localparam int DEPTH = 64;
    localparam int NBYTES = 4 * DEPTH;

    logic        CLK;
    logic        RST;
    logic [31:0] address;
    logic [31:0] dataWr;
    logic        dmWr;
    logic [2:0]  dmCtrl;
    logic [31:0] dataRd;

    int tests_run;
    int tests_failed;

    logic [7:0] ref_mem [NBYTES];

    typedef struct {
        logic        rst;
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    data_memory #(.DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .address (address),
        .dataWr  (dataWr),
        .dmWr    (dmWr),
        .dmCtrl  (dmCtrl),
        .dataRd  (dataRd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic chk, input logic [31:0] exp);
        vec_t v;
        v.rst = rst; v.wr = wr; v.ctrl = ctrl; v.addr = addr;
        v.wdata = wdata; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] ctrl);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        a = int'(addr) % NBYTES;
        if (a < 0) a += NBYTES;
        b = ref_mem[a];
        h = {ref_mem[(a & ~1) + 1], ref_mem[a & ~1]};
        case (ctrl)
            3'b000:  return (b >= 8'd128) ? 32'hFFFF_FF00 + 32'(b) : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 16'd32768) ? 32'hFFFF_0000 + 32'(h) : 32'(h);
            3'b101:  return 32'(h);
            3'b010:  return {ref_mem[(a & ~3) + 3], ref_mem[(a & ~3) + 2],
                             ref_mem[(a & ~3) + 1], ref_mem[a & ~3]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_update(input logic rst, input logic wr, input logic [2:0] ctrl,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int a;
        int n;
        int base;
        a = int'(addr[7:0]);
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        end else if (wr) begin
            case (ctrl[1:0])
                2'b00:   begin n = 1; base = a; end
                2'b01:   begin n = 2; base = a & ~1; end
                2'b10:   begin n = 4; base = a & ~3; end
                default: begin n = 0; base = 0; end
            endcase
            for (int k = 0; k < n; k++) ref_mem[base + k] = wdata[8*k +: 8];
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        RST = 1'b0; dmWr = 1'b0; dmCtrl = 3'b010; address = 32'h0; dataWr = 32'h0;

        // rst wr ctrl addr wdata chk exp
        add(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0004, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b0, 3'b010, 32'h0000_00FC, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF);
        add(1'b0, 1'b0, 3'b100, 32'h0000_0010, 32'h0, 1'b1, 32'h0000_00EF);
        add(1'b0, 1'b0, 3'b100, 32'h0000_0011, 32'h0, 1'b1, 32'h0000_00BE);
        add(1'b0, 1'b0, 3'b100, 32'h0000_0012, 32'h0, 1'b1, 32'h0000_00AD);
        add(1'b0, 1'b0, 3'b100, 32'h0000_0013, 32'h0, 1'b1, 32'h0000_00DE);
        add(1'b0, 1'b0, 3'b000, 32'h0000_0013, 32'h0, 1'b1, 32'hFFFF_FFDE);
        add(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0);
        add(1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'hFFFF_FFAA, 1'b0, 32'h0);
        add(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_8001, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 1'b1, 32'h8001_AA44);
        add(1'b0, 1'b0, 3'b001, 32'h0000_0022, 32'h0, 1'b1, 32'hFFFF_8001);
        add(1'b0, 1'b0, 3'b101, 32'h0000_0022, 32'h0, 1'b1, 32'h0000_8001);
        add(1'b0, 1'b0, 3'b000, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_0044);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0030, 32'h5555_5555, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0030, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b1, 3'b011, 32'h0000_0030, 32'h7777_7777, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b011, 32'h0000_0030, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0030, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 1'b1, 32'hCAFE_F00D);
        add(1'b0, 1'b1, 3'b010, 32'h0000_0053, 32'h0BAD_F00D, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0050, 32'h0, 1'b1, 32'h0BAD_F00D);
        add(1'b0, 1'b0, 3'b001, 32'h0000_0051, 32'h0, 1'b1, 32'hFFFF_F00D);
        add(1'b0, 1'b1, 3'b100, 32'h0000_0061, 32'h0000_0080, 1'b0, 32'h0);
        add(1'b0, 1'b1, 3'b101, 32'h0000_0062, 32'h0000_BEEF, 1'b0, 32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_0060, 32'h0, 1'b1, 32'hBEEF_8000);
        add(1'b0, 1'b0, 3'b110, 32'h0000_0060, 32'h0, 1'b1, 32'h0000_0000);
        add(1'b0, 1'b0, 3'b111, 32'h0000_0060, 32'h0, 1'b1, 32'h0000_0000);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst; dmWr = vecs[i].wr; dmCtrl = vecs[i].ctrl;
            address = vecs[i].addr; dataWr = vecs[i].wdata;
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d", i), dataRd, vecs[i].exp);
            @(posedge CLK);
        end

        // Read during write: old contents before the edge, new contents after.
        @(negedge CLK);
        RST = 1'b0; dmWr = 1'b1; dmCtrl = 3'b010; address = 32'h0000_0060; dataWr = 32'h1111_1111;
        #1 check("rdw_old", dataRd, 32'hBEEF_8000);
        @(posedge CLK);
        #1 check("rdw_new", dataRd, 32'h1111_1111);
        @(negedge CLK);
        dmWr = 1'b0;

        // Randomized traffic against the byte-array model.
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        @(negedge CLK);
        RST = 1'b1; dmWr = 1'b0;
        @(posedge CLK);
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            RST     = ($urandom_range(0, 49) == 0);
            dmWr    = ($urandom_range(0, 9) < 6);
            dmCtrl  = 3'($urandom_range(0, 7));
            address = (n % 3 == 0) ? $urandom() : 32'($urandom_range(0, NBYTES - 1));
            dataWr  = $urandom();
            #1 check($sformatf("rand%0d", n), dataRd, model_read(address, dmCtrl));
            @(posedge CLK);
            model_update(RST, dmWr, dmCtrl, address, dataWr);
        end

        @(negedge CLK);
        RST = 1'b0; dmWr = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
